pe_weight_loader: RTL and testbench

- Upstream weight feeder for the systolic array. Drives the `bin`/`bin_slot`/`bin_val` inputs of the top PE in every column.
- Accepts a weight tile as ROWS beats of COLS lanes on a valid/ready stream. Shifts the tile down the columns into the idle (shadow) weight slot.
- Tracks which of the two double-buffer slots holds a complete tile, and hands that slot to the activation feeder.
- Loading of one slot overlaps compute on the other.

---
 rtl/pe_weight_loader.sv | 174 +++++++++++++++++
 tb/tb_pe_weight_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_weight_loader.sv
// pe_weight_loader: weight feeder for the top PE row of the systolic array.
// Accepts a weight tile as ROWS beats of COLS lanes, streams it into the
// idle (shadow) slot of the PE columns and tracks which of the two
// double-buffer slots holds a complete tile for the activation feeder.
// Optional protocol-error checking is built when PE_WLD_ERR_EN is defined.
module pe_weight_loader #(
    parameter int WIDTH = 4,
    parameter int ROWS  = 4,
    parameter int COLS  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [COLS*WIDTH-1:0] s_wt_data,
    input  logic                  s_wt_valid,
    output logic                  s_wt_ready,
    output logic [COLS*WIDTH-1:0] bin,
    output logic [COLS-1:0]       bin_slot,
    output logic [COLS-1:0]       bin_val,
    output logic                  tile_valid,
    output logic                  tile_slot,
    input  logic                  tile_release,
    output logic                  err
);

    localparam int CW = $clog2(ROWS + 1);
    localparam logic [CW-1:0] LAST = CW'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [CW-1:0]           r_beat_cnt, w_beat_cnt_nxt;
    logic [CW-1:0]           r_drain_cnt, w_drain_cnt_nxt;
    logic [1:0]              r_full, w_full_nxt;
    logic                    r_wr_slot, w_wr_slot_nxt;
    logic                    r_rd_slot, w_rd_slot_nxt;
    logic                    r_ready, w_ready_nxt;
    logic [COLS*WIDTH-1:0]   r_bin;
    logic [COLS-1:0]         r_bin_slot;
    logic [COLS-1:0]         r_bin_val;
    logic                    r_tile_valid;
    logic                    r_tile_slot;

    logic w_accept;
    logic w_release;

    assign w_accept  = s_wt_valid & r_ready;
    // A release only counts when the consumer actually owns a complete tile.
    assign w_release = tile_release & r_full[r_rd_slot];

    // Next-state, slot bookkeeping and next-cycle ready.
    always_comb begin
        w_state_nxt     = r_state;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_drain_cnt_nxt = r_drain_cnt;
        w_full_nxt      = r_full;
        w_wr_slot_nxt   = r_wr_slot;
        w_rd_slot_nxt   = r_rd_slot;
        w_ready_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_beat_cnt_nxt = CW'(1);
                    w_state_nxt    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    if (r_beat_cnt == LAST) begin
                        w_beat_cnt_nxt = '0;
                        w_state_nxt    = ST_DRAIN;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + CW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // ROWS cycles lets the last beat reach the bottom PE.
                if (r_drain_cnt == LAST) begin
                    w_drain_cnt_nxt        = '0;
                    w_full_nxt[r_wr_slot]  = 1'b1;
                    w_wr_slot_nxt          = ~r_wr_slot;
                    w_state_nxt            = ST_IDLE;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Completion writes wr_slot, release clears rd_slot; they never
        // coincide on the same slot, so both updates can apply.
        if (w_release) begin
            w_full_nxt[r_rd_slot] = 1'b0;
            w_rd_slot_nxt         = ~r_rd_slot;
        end

        case (w_state_nxt)
            ST_LOAD: w_ready_nxt = 1'b1;
            ST_IDLE: w_ready_nxt = ~w_full_nxt[w_wr_slot_nxt];
            default: w_ready_nxt = 1'b0;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
            r_full      <= 2'b00;
            r_wr_slot   <= 1'b0;
            r_rd_slot   <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_full      <= w_full_nxt;
            r_wr_slot   <= w_wr_slot_nxt;
            r_rd_slot   <= w_rd_slot_nxt;
            r_ready     <= w_ready_nxt;
        end
    end

    // Output pipe to the top PEs and registered consumer-side view.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin        <= '0;
            r_bin_val    <= '0;
            r_bin_slot   <= '0;
            r_tile_valid <= 1'b0;
            r_tile_slot  <= 1'b0;
        end else begin
            r_bin        <= w_accept ? s_wt_data : '0;
            r_bin_val    <= {COLS{w_accept}};
            r_bin_slot   <= {COLS{r_wr_slot}};
            r_tile_valid <= w_full_nxt[w_rd_slot_nxt];
            r_tile_slot  <= w_rd_slot_nxt;
        end
    end

`ifdef PE_WLD_ERR_EN
    logic r_err;

    // Sticky error: spurious release or a bubble in the middle of a tile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if ((tile_release && !r_full[r_rd_slot]) ||
                     (r_state == ST_LOAD && !s_wt_valid)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign s_wt_ready = r_ready;
    assign bin        = r_bin;
    assign bin_val    = r_bin_val;
    assign bin_slot   = r_bin_slot;
    assign tile_valid = r_tile_valid;
    assign tile_slot  = r_tile_slot;

endmodule

// File: tb/tb_pe_weight_loader.sv
// Directed bench for pe_weight_loader (WIDTH=ROWS=COLS=4), with a small
// column-shift model of the PE weight slots fed from bin/bin_val/bin_slot.
module tb_pe_weight_loader;

    localparam int WIDTH = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;

`ifdef PE_WLD_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic                  clk;
    logic                  rst_n;
    logic [COLS*WIDTH-1:0] s_wt_data;
    logic                  s_wt_valid;
    logic                  s_wt_ready;
    logic [COLS*WIDTH-1:0] bin;
    logic [COLS-1:0]       bin_slot;
    logic [COLS-1:0]       bin_val;
    logic                  tile_valid;
    logic                  tile_slot;
    logic                  tile_release;
    logic                  err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] pe [2][ROWS][COLS];

    logic [15:0] ta [4];
    logic [15:0] tb [4];
    logic [15:0] tc [4];

    pe_weight_loader #(.WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_wt_data    (s_wt_data),
        .s_wt_valid   (s_wt_valid),
        .s_wt_ready   (s_wt_ready),
        .bin          (bin),
        .bin_slot     (bin_slot),
        .bin_val      (bin_val),
        .tile_valid   (tile_valid),
        .tile_slot    (tile_slot),
        .tile_release (tile_release),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PE column model: each write shifts the addressed slot down one row.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++)
                for (int r = 0; r < ROWS; r++)
                    for (int j = 0; j < COLS; j++)
                        pe[s][r][j] <= '0;
        end else begin
            for (int j = 0; j < COLS; j++) begin
                if (bin_val[j]) begin
                    for (int r = ROWS - 1; r > 0; r--)
                        pe[bin_slot[j]][r][j] <= pe[bin_slot[j]][r-1][j];
                    pe[bin_slot[j]][0][j] <= bin[j*WIDTH +: WIDTH];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ta[0] = 16'h4321; ta[1] = 16'h8765; ta[2] = 16'hCBA9; ta[3] = 16'h0FED;
        tb[0] = 16'h1111; tb[1] = 16'h2222; tb[2] = 16'h3333; tb[3] = 16'h4444;
        tc[0] = 16'h0001; tc[1] = 16'h0002; tc[2] = 16'h0003; tc[3] = 16'h0004;

        rst_n = 1'b0; s_wt_valid = 1'b0; s_wt_data = '0; tile_release = 1'b0;
        #3;
        chk("rst_ready", s_wt_ready, 0);
        chk("rst_bin", bin, 0);
        chk("rst_bin_val", bin_val, 0);
        chk("rst_bin_slot", bin_slot, 0);
        chk("rst_tile_valid", tile_valid, 0);
        chk("rst_tile_slot", tile_slot, 0);
        chk("rst_err", err, 0);
        cyc(); cyc();
        #4 rst_n = 1'b1;
        cyc();
        chk("ready_after_reset", s_wt_ready, 1);

        // Single tile into slot 0
        for (int k = 0; k < 4; k++) begin
            s_wt_data = ta[k]; s_wt_valid = 1'b1;
            cyc();
            chk("t1_bin", bin, ta[k]);
            chk("t1_bin_val", bin_val, 4'hF);
            chk("t1_bin_slot", bin_slot, 4'h0);
        end
        s_wt_valid = 1'b0; s_wt_data = '0;
        chk("t1_ready_drain", s_wt_ready, 0);
        chk("t1_tv_early", tile_valid, 0);
        repeat (3) cyc();
        chk("t1_tv_before", tile_valid, 0);
        chk("t1_bin_val_idle", bin_val, 0);
        cyc();
        chk("t1_tv_rise", tile_valid, 1);
        chk("t1_tile_slot", tile_slot, 0);
        chk("t1_ready_idle", s_wt_ready, 1);
        chk("t1_err", err, 0);
        chk("t1_pe30", pe[0][3][0], 4'h1);
        chk("t1_pe00", pe[0][0][0], 4'hD);
        chk("t1_pe33", pe[0][3][3], 4'h4);

        // Release slot 0
        tile_release = 1'b1; cyc(); tile_release = 1'b0;
        chk("rel0_tv", tile_valid, 0);
        chk("rel0_slot", tile_slot, 1);
        chk("rel0_ready", s_wt_ready, 1);

        // Gapped tile into slot 1
        s_wt_data = ta[0]; s_wt_valid = 1'b1; cyc();
        chk("t2_bv0", bin_val, 4'hF);
        chk("t2_slot", bin_slot, 4'hF);
        s_wt_data = ta[1]; cyc();
        chk("t2_bv1", bin_val, 4'hF);
        chk("t2_bin1", bin, ta[1]);
        s_wt_valid = 1'b0; s_wt_data = '0; cyc();
        chk("t2_bv_gap", bin_val, 4'h0);
        chk("t2_bin_gap", bin, 0);
        chk("t2_ready_gap", s_wt_ready, 1);
        s_wt_data = ta[2]; s_wt_valid = 1'b1; cyc();
        chk("t2_bv3", bin_val, 4'hF);
        chk("t2_bin3", bin, ta[2]);
        s_wt_data = ta[3]; cyc();
        chk("t2_bv4", bin_val, 4'hF);
        chk("t2_ready_drain", s_wt_ready, 0);
        s_wt_valid = 1'b0; s_wt_data = '0;
        repeat (3) cyc();
        chk("t2_tv_before", tile_valid, 0);
        cyc();
        chk("t2_tv_rise", tile_valid, 1);
        chk("t2_tile_slot", tile_slot, 1);
        chk("t2_err", err, ERR_EN);
        chk("t2_pe30", pe[1][3][0], 4'h1);
        chk("t2_pe00", pe[1][0][0], 4'hD);

        // Tile B into slot 0 -> both slots full
        for (int k = 0; k < 4; k++) begin
            s_wt_data = tb[k]; s_wt_valid = 1'b1;
            cyc();
            chk("t3_bin", bin, tb[k]);
            chk("t3_bin_slot", bin_slot, 4'h0);
        end
        s_wt_valid = 1'b0; s_wt_data = '0;
        repeat (4) cyc();
        chk("t3_tv", tile_valid, 1);
        chk("t3_tile_slot", tile_slot, 1);
        chk("t3_ready_full", s_wt_ready, 0);
        chk("t3_pe31", pe[0][3][1], 4'h1);
        chk("t3_pe01", pe[0][0][1], 4'h4);

        // Third tile stalls until a release
        s_wt_data = tc[0]; s_wt_valid = 1'b1;
        repeat (3) cyc();
        chk("stall_ready", s_wt_ready, 0);
        chk("stall_bin_val", bin_val, 0);
        tile_release = 1'b1; cyc(); tile_release = 1'b0;
        chk("stall_rel_ready", s_wt_ready, 1);
        chk("stall_rel_slot", tile_slot, 0);
        chk("stall_rel_tv", tile_valid, 1);
        for (int k = 0; k < 4; k++) begin
            s_wt_data = tc[k]; s_wt_valid = 1'b1;
            cyc();
            chk("t4_bin", bin, tc[k]);
            chk("t4_bin_slot", bin_slot, 4'hF);
        end
        s_wt_valid = 1'b0; s_wt_data = '0;
        chk("t4_ready_drain", s_wt_ready, 0);
        repeat (3) cyc();
        chk("t4_slot_before", tile_slot, 0);
        // Release slot 0 on the edge slot 1 completes
        tile_release = 1'b1; cyc(); tile_release = 1'b0;
        chk("sim_tv", tile_valid, 1);
        chk("sim_slot", tile_slot, 1);
        chk("sim_ready", s_wt_ready, 1);
        chk("t4_pe30", pe[1][3][0], 4'h1);
        chk("t4_pe00", pe[1][0][0], 4'h4);

        // Release slot 1 -> nothing left
        tile_release = 1'b1; cyc(); tile_release = 1'b0;
        chk("rel1_tv", tile_valid, 0);
        chk("rel1_slot", tile_slot, 0);

        // Reset in the middle of a load
        s_wt_data = ta[0]; s_wt_valid = 1'b1; cyc();
        s_wt_data = ta[1]; cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", s_wt_ready, 0);
        chk("mid_rst_bin_val", bin_val, 0);
        chk("mid_rst_bin", bin, 0);
        chk("mid_rst_tv", tile_valid, 0);
        chk("mid_rst_err", err, 0);
        s_wt_valid = 1'b0; s_wt_data = '0;
        #2 rst_n = 1'b1;
        cyc();
        chk("post_rst_ready", s_wt_ready, 1);
        chk("post_rst_tv", tile_valid, 0);

        // Spurious release
        tile_release = 1'b1; cyc(); tile_release = 1'b0;
        chk("spur_tv", tile_valid, 0);
        chk("spur_slot", tile_slot, 0);
        chk("spur_ready", s_wt_ready, 1);
        chk("spur_err", err, ERR_EN);

        // Fresh tile after reset lands in slot 0
        for (int k = 0; k < 4; k++) begin
            s_wt_data = ta[k]; s_wt_valid = 1'b1;
            cyc();
            chk("t5_bin", bin, ta[k]);
            chk("t5_bin_slot", bin_slot, 4'h0);
        end
        s_wt_valid = 1'b0; s_wt_data = '0;
        repeat (4) cyc();
        chk("t5_tv", tile_valid, 1);
        chk("t5_slot", tile_slot, 0);
        chk("t5_pe30", pe[0][3][0], 4'h1);
        chk("t5_pe20", pe[0][2][0], 4'h5);
        chk("t5_pe00", pe[0][0][0], 4'hD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
